// File: rtl/pc_source_if.sv
// Bus bundle between the multicycle control/datapath and the PC source unit.
// The control side drives the master modport; the PC unit sits on the slave modport.
interface pc_source_if #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NSRC       = 5,
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned EXC_CODE_W = 2
);
   logic [NSRC*WIDTH-1:0]  src_in;
   logic [SEL_W-1:0]       sel;
   logic                   pc_write;
   logic                   pc_write_cond;
   logic                   cond_true;
   logic                   exc_req;
   logic [EXC_CODE_W-1:0]  exc_code;
   logic                   eret;
   logic [WIDTH-1:0]       pc_out;
   logic [WIDTH-1:0]       epc_out;
   logic [WIDTH-1:0]       pc_next;
   logic                   in_exc;
   logic                   sel_err;
   logic                   sel_err_sticky;
   logic                   exc_drop;

   modport master (
      output src_in, sel, pc_write, pc_write_cond, cond_true, exc_req, exc_code, eret,
      input  pc_out, epc_out, pc_next, in_exc, sel_err, sel_err_sticky, exc_drop
   );

   modport slave (
      input  src_in, sel, pc_write, pc_write_cond, cond_true, exc_req, exc_code, eret,
      output pc_out, epc_out, pc_next, in_exc, sel_err, sel_err_sticky, exc_drop
   );
endinterface

// File: rtl/pc_source_unit.sv
// Program-counter source select and update unit: holds PC/EPC, applies the
// write enables and sequences exception entry/return through a RUN/EXC machine.
module pc_source_unit #(
   parameter int unsigned     WIDTH      = 32,
   parameter int unsigned     NSRC       = 5,
   parameter int unsigned     SEL_W      = 3,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] EXC_BASE  = WIDTH'(32'h0000_00FC),
   parameter int unsigned     EXC_CODE_W = 2,
   parameter int unsigned     INST_BYTES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   pc_source_if.slave  bus
);

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_EXC = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             sel_err_q, sel_err_d;
   logic             sticky_q, sticky_d;
   logic             exc_drop_q, exc_drop_d;

   logic             ld;
   logic             sel_ok;
   logic [WIDTH-1:0] src_sel;

   assign ld = bus.pc_write | (bus.pc_write_cond & bus.cond_true);

   // Source mux; an out-of-range select simply matches no candidate.
   always_comb begin
      sel_ok  = 1'b0;
      src_sel = '0;
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            sel_ok  = 1'b1;
            src_sel = bus.src_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic; priority is exception entry > eret > load > hold.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      sel_err_d  = 1'b0;
      exc_drop_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bus.exc_req) begin
               epc_d   = pc_q - WIDTH'(INST_BYTES);
               pc_d    = EXC_BASE + WIDTH'(bus.exc_code) * WIDTH'(INST_BYTES);
               state_d = ST_EXC;
            end else if (ld) begin
               if (sel_ok) pc_d = src_sel;
               else        sel_err_d = 1'b1;
            end
         end
         default: begin
            exc_drop_d = bus.exc_req;
            if (bus.eret) begin
               pc_d    = epc_q;
               state_d = ST_RUN;
            end else if (ld) begin
               if (sel_ok) pc_d = src_sel;
               else        sel_err_d = 1'b1;
            end
         end
      endcase

      sticky_d = sticky_q | sel_err_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         epc_q      <= '0;
         sel_err_q  <= 1'b0;
         sticky_q   <= 1'b0;
         exc_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         sel_err_q  <= sel_err_d;
         sticky_q   <= sticky_d;
         exc_drop_q <= exc_drop_d;
      end
   end

   assign bus.pc_out         = pc_q;
   assign bus.epc_out        = epc_q;
   assign bus.pc_next        = pc_d;
   assign bus.in_exc         = (state_q == ST_EXC);
   assign bus.sel_err        = sel_err_q;
   assign bus.sel_err_sticky = sticky_q;
   assign bus.exc_drop       = exc_drop_q;

endmodule
